addsub16_serial: RTL and testbench

ADDSUB16_SERIAL -- requirements
Module: addsub16_serial

---
 rtl/addsub16_pkg.sv | 8 +
 rtl/sum4.sv | 23 ++
 rtl/addsub16_serial.sv | 76 +++++++
 tb/tb_addsub16_serial.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/addsub16_pkg.sv
// addsub16_pkg: shared state encodings and constants for the nibble-serial 16-bit adder/subtractor.
package addsub16_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NIBBLES = 4;
    localparam logic [1:0] LAST = 2'(NIBBLES - 1);
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/sum4.sv
// sum4: 4-bit carry-lookahead adder.
module sum4 (
    output logic [3:0] S,
    output logic       C_out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in
);
    logic [3:0] g, p;
    logic [4:0] c;
    always_comb begin
        g = A & B;
        p = A ^ B;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        S = p ^ c[3:0];
        C_out = c[4];
    end
endmodule

// File: rtl/addsub16_serial.sv
// addsub16_serial: 16-bit add/subtract computed one nibble per cycle through a single sum4.
// Define ADDSUB16_OVF_EN to add the registered signed-overflow output ovf.
module addsub16_serial
    import addsub16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] s,
    output logic        c_out
`ifdef ADDSUB16_OVF_EN
    ,
    output logic        ovf
`endif
);
    state_t state, state_nxt;
    logic [1:0] cnt;
    logic carry, op_r, take, nib_c;
    logic [15:0] a_r, b_r;
    logic [3:0] a_n, b_n, nib_s;
    always_comb begin
        take = start && (state == IDLE || state == DONE);
        state_nxt = state;
        case (state)
            IDLE: state_nxt = start ? RUN : IDLE;
            RUN:  state_nxt = (cnt == LAST) ? DONE : RUN;
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        a_n = a_r[{cnt, 2'b00} +: 4];
        b_n = (op_r == OP_ADD) ? b_r[{cnt, 2'b00} +: 4] : ~b_r[{cnt, 2'b00} +: 4];
        busy = (state == RUN);
        done = (state == DONE);
    end
    sum4 u_add (.S(nib_s), .C_out(nib_c), .A(a_n), .B(b_n), .c_in(carry));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            carry <= 1'b0;
            op_r <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            s <= '0;
            c_out <= 1'b0;
`ifdef ADDSUB16_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                a_r <= a;
                b_r <= b;
                op_r <= op;
                cnt <= '0;
                carry <= (op == OP_SUB);
            end else if (state == RUN) begin
                s[{cnt, 2'b00} +: 4] <= nib_s;
                carry <= nib_c;
                cnt <= cnt + 2'd1;
                if (cnt == LAST) begin
                    c_out <= nib_c;
`ifdef ADDSUB16_OVF_EN
                    // carry into bit 15 recovered from its sum bit
                    ovf <= a_n[3] ^ b_n[3] ^ nib_s[3] ^ nib_c;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub16_serial.sv
// tb_addsub16_serial: directed self-checking bench for addsub16_serial.
module tb_addsub16_serial;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic busy, done, c_out;
    logic [15:0] s;
`ifdef ADDSUB16_OVF_EN
    logic ovf;
`endif
    int errors = 0, checks = 0;
    int lat, bcnt, seen;
    always #5 clk = ~clk;
    addsub16_serial dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .c_out(c_out)
`ifdef ADDSUB16_OVF_EN
        , .ovf(ovf)
`endif
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_done(output int l, output int bc);
        l = 1;
        bc = 0;
        while (!done && l < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_s", 32'(s), 0);
        check("rst_cout", 32'(c_out), 0);
`ifdef ADDSUB16_OVF_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        reset = 1'b0;
        do_op(1'b0, 16'h0000, 16'h0000);
        check("zero_lat", 32'(lat), 5);
        check("zero_busy", 32'(bcnt), 4);
        check("zero_s", 32'(s), 32'h0000);
        check("zero_c", 32'(c_out), 0);
        @(posedge clk);
        #1;
        check("zero_pulse", 32'(done), 0);
        check("zero_idle", 32'(busy), 0);
        do_op(1'b0, 16'hFFFF, 16'h0001);
        check("wrap_s", 32'(s), 32'h0000);
        check("wrap_c", 32'(c_out), 1);
`ifdef ADDSUB16_OVF_EN
        check("wrap_ovf", 32'(ovf), 0);
`endif
        do_op(1'b1, 16'h0000, 16'h0001);
        check("borrow_s", 32'(s), 32'hFFFF);
        check("borrow_c", 32'(c_out), 0);
        do_op(1'b1, 16'h5555, 16'h1111);
        check("sub_s", 32'(s), 32'h4444);
        check("sub_c", 32'(c_out), 1);
        do_op(1'b0, 16'h7FFF, 16'h0001);
        check("ovf_s", 32'(s), 32'h8000);
        check("ovf_c", 32'(c_out), 0);
`ifdef ADDSUB16_OVF_EN
        check("ovf_flag", 32'(ovf), 1);
`endif
        // start re-pulsed during RUN cycle 2
        @(negedge clk);
        op = 1'b0; a = 16'h0100; b = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; a = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 3;
        bcnt = 2;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_lat", 32'(lat), 5);
        check("ign_s", 32'(s), 32'h0102);
        @(posedge clk);
        #1;
        check("ign_idle", 32'(busy), 0);
        // reset during RUN cycle 3
        @(negedge clk);
        op = 1'b0; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_s", 32'(s), 0);
        check("abort_c", 32'(c_out), 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("abort_quiet", 32'(seen), 0);
        // start held high through DONE for back-to-back operations
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0F0F; b = 16'h00F1;
        wait_done(lat, bcnt);
        check("b2b_lat1", 32'(lat), 5);
        check("b2b_s1", 32'(s), 32'h3333);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_rerun", 32'(busy), 1);
        wait_done(lat, bcnt);
        check("b2b_lat2", 32'(lat), 5);
        check("b2b_s2", 32'(s), 32'h1000);
        check("b2b_c2", 32'(c_out), 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_s", 32'(s), 32'h1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
